pipe_ctrl_n: RTL and testbench

- Parametrised pipeline hazard and control unit for the RV32IM core family. Generalises the fixed 5-stage stall/flush controller to NSTAGE stages, with configurable stages for hazard detection and jump resolution.
- Adds a halt/drain/resume state machine, a multi-cycle-unit stall path and saturating performance counters.
- Sits beside the core top. It drives per-stage stall/flush vectors and the PC redirect.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_ctrl_n.sv | 160 ++++++++++++++++
 tb/tb_pipe_ctrl_n.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the parametrised pipeline hazard/control unit.
// Stage-index defaults match the 5-stage RV32IM core (PC, IF, ID, EXE, MEM/WB).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int DEF_NSTAGE     = 5;
  localparam int DEF_LU_STAGE   = 2;
  localparam int DEF_JMP_STAGE  = 3;
  localparam int DEF_MC_STAGE   = 3;
  localparam int DEF_HALT_STAGE = 4;

  // Masks are built at this width and truncated to NSTAGE by the user.
  localparam int MAX_STAGE = 32;
  typedef logic [MAX_STAGE-1:0] stage_vec_t;

  function automatic stage_vec_t range_mask(input int hi, input int lo);
    stage_vec_t m;
    m = '0;
    for (int i = 0; i < MAX_STAGE; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all ones instead of wrapping.
// One-cycle latency from inc_i to cnt_o; no backpressure.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline stall/flush/redirect controller with halt-drain-resume FSM and perf counters.
// Control vectors are combinational (zero latency); FSM and counters update at the edge.
module pipe_ctrl_n
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NSTAGE     = DEF_NSTAGE,
  parameter int LU_STAGE   = DEF_LU_STAGE,
  parameter int JMP_STAGE  = DEF_JMP_STAGE,
  parameter int MC_STAGE   = DEF_MC_STAGE,
  parameter int HALT_STAGE = DEF_HALT_STAGE,
  parameter int CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              loaduse_hazard_i,
  input  logic              mc_busy_i,
  input  logic              je_i,
  input  logic [XLEN-1:0]   jump_addr_i,
  input  logic              halt_req_i,
  input  logic              resume_i,
  input  logic [XLEN-1:0]   resume_addr_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              je_o,
  output logic [XLEN-1:0]   jump_addr_o,
  output logic              halted_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  if (!(1 < LU_STAGE && LU_STAGE < JMP_STAGE && JMP_STAGE <= MC_STAGE &&
        MC_STAGE < HALT_STAGE && HALT_STAGE < NSTAGE)) begin : g_param_err
    $error("pipe_ctrl_n: illegal stage parameters");
  end

  localparam int DW = $clog2(NSTAGE + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(NSTAGE - HALT_STAGE);

  localparam logic [NSTAGE-1:0] M_ST0     = NSTAGE'(range_mask(0, 0));
  localparam logic [NSTAGE-1:0] M_FL1     = NSTAGE'(range_mask(1, 1));
  localparam logic [NSTAGE-1:0] M_HALT_FL = NSTAGE'(range_mask(HALT_STAGE - 1, 1));
  localparam logic [NSTAGE-1:0] M_MC_ST   = NSTAGE'(range_mask(MC_STAGE, 0));
  localparam logic [NSTAGE-1:0] M_MC_FL   = NSTAGE'(range_mask(MC_STAGE + 1, MC_STAGE + 1));
  localparam logic [NSTAGE-1:0] M_JMP_FL  = NSTAGE'(range_mask(JMP_STAGE - 1, 1));
  localparam logic [NSTAGE-1:0] M_LU_ST   = NSTAGE'(range_mask(LU_STAGE, 0));
  localparam logic [NSTAGE-1:0] M_LU_FL   = NSTAGE'(range_mask(LU_STAGE + 1, LU_STAGE + 1));
  localparam logic [NSTAGE-1:0] M_ALL_FL  = NSTAGE'(range_mask(NSTAGE - 1, 1));

  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Drain leaves on the edge where the counter would reach zero; mc_busy freezes it.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req_i) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (!mc_busy_i) begin
          if (drain_q <= DW'(1)) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      ST_HALTED: begin
        if (resume_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_o     = '0;
    flush_o     = '0;
    je_o        = 1'b0;
    jump_addr_o = '0;
    halted_o    = 1'b0;
    if (rst_i) begin
      flush_o = '1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_req_i) begin
            stall_o = M_ST0;
            flush_o = M_HALT_FL;
          end else if (mc_busy_i) begin
            stall_o = M_MC_ST;
            flush_o = M_MC_FL;
          end else if (je_i) begin
            je_o        = 1'b1;
            jump_addr_o = jump_addr_i;
            flush_o     = M_JMP_FL;
          end else if (loaduse_hazard_i) begin
            stall_o = M_LU_ST;
            flush_o = M_LU_FL;
          end
        end
        ST_DRAIN: begin
          stall_o = M_ST0;
          flush_o = M_FL1;
          if (mc_busy_i) begin
            stall_o = stall_o | M_MC_ST;
            flush_o = flush_o | M_MC_FL;
          end
        end
        ST_HALTED: begin
          halted_o = 1'b1;
          if (resume_i) begin
            je_o        = 1'b1;
            jump_addr_o = resume_addr_i;
            flush_o     = M_ALL_FL;
          end else begin
            stall_o = '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

  logic stall_inc;
  assign stall_inc = (state_q == ST_RUN) && stall_o[0];

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (je_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed bench for pipe_ctrl_n: default 5-stage instance plus a CNT_W=4 instance.
module tb_pipe_ctrl_n;

  logic        clk = 1'b0;
  logic        rst_i, loaduse_hazard_i, mc_busy_i, je_i, halt_req_i, resume_i;
  logic [31:0] jump_addr_i, resume_addr_i;
  logic [4:0]  stall_o, flush_o;
  logic        je_o, halted_o;
  logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;
  logic [1:0]  state_o;

  logic [4:0]  s_stall, s_flush;
  logic        s_je, s_halted;
  logic [31:0] s_addr;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_n u_dut (
    .clk_i(clk), .rst_i(rst_i), .loaduse_hazard_i(loaduse_hazard_i),
    .mc_busy_i(mc_busy_i), .je_i(je_i), .jump_addr_i(jump_addr_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i), .resume_addr_i(resume_addr_i),
    .stall_o(stall_o), .flush_o(flush_o), .je_o(je_o), .jump_addr_o(jump_addr_o),
    .halted_o(halted_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_ctrl_n #(.CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .loaduse_hazard_i(loaduse_hazard_i),
    .mc_busy_i(mc_busy_i), .je_i(je_i), .jump_addr_i(jump_addr_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i), .resume_addr_i(resume_addr_i),
    .stall_o(s_stall), .flush_o(s_flush), .je_o(s_je), .jump_addr_o(s_addr),
    .halted_o(s_halted), .state_o(s_state),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    loaduse_hazard_i = 1'b0; mc_busy_i = 1'b0; je_i = 1'b0; halt_req_i = 1'b0;
    resume_i = 1'b0; jump_addr_i = '0; resume_addr_i = '0;
  endtask

  task automatic apply_reset;
    clear_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_i = 1'b1;
    tick();
    #1;
    checks++; if (stall_o !== 5'b00000) begin errors++; $display("FAIL rst_stall: got %b want 00000", stall_o); end
    checks++; if (flush_o !== 5'b11111) begin errors++; $display("FAIL rst_flush: got %b want 11111", flush_o); end
    checks++; if (je_o !== 1'b0 || jump_addr_o !== 32'h0) begin errors++; $display("FAIL rst_je: got %b/%h want 0/0", je_o, jump_addr_o); end
    checks++; if (halted_o !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %b/%0d want 0/0", halted_o, state_o); end
    checks++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_loaduse;
    apply_reset();
    loaduse_hazard_i = 1'b1;
    #1;
    checks++; if (stall_o !== 5'b00111) begin errors++; $display("FAIL lu_stall: got %b want 00111", stall_o); end
    checks++; if (flush_o !== 5'b01000) begin errors++; $display("FAIL lu_flush: got %b want 01000", flush_o); end
    checks++; if (je_o !== 1'b0) begin errors++; $display("FAIL lu_je: got %b want 0", je_o); end
    tick();
    loaduse_hazard_i = 1'b0;
    #1;
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o); end
    checks++; if (stall_o !== 5'b0 || flush_o !== 5'b0) begin errors++; $display("FAIL lu_idle: got %b/%b want 0/0", stall_o, flush_o); end
  endtask

  task automatic test_jump_loaduse;
    apply_reset();
    je_i = 1'b1; jump_addr_i = 32'h0000_0100; loaduse_hazard_i = 1'b1;
    #1;
    checks++; if (je_o !== 1'b1 || jump_addr_o !== 32'h100) begin errors++; $display("FAIL jmp_redirect: got %b/%h want 1/00000100", je_o, jump_addr_o); end
    checks++; if (flush_o !== 5'b00110) begin errors++; $display("FAIL jmp_flush: got %b want 00110", flush_o); end
    checks++; if (stall_o !== 5'b00000) begin errors++; $display("FAIL jmp_stall: got %b want 00000", stall_o); end
    tick();
    clear_inputs();
    #1;
    checks++; if (flush_cnt_o !== 32'd1) begin errors++; $display("FAIL jmp_fcnt: got %0d want 1", flush_cnt_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL jmp_scnt: got %0d want 0", stall_cnt_o); end
  endtask

  task automatic test_mc_busy;
    apply_reset();
    mc_busy_i = 1'b1; je_i = 1'b1; jump_addr_i = 32'h0000_0200;
    for (int i = 0; i < 34; i++) begin
      #1;
      checks++;
      if (stall_o !== 5'b01111 || flush_o !== 5'b10000 || je_o !== 1'b0) begin
        errors++;
        $display("FAIL mc_hold[%0d]: got stall %b flush %b je %b want 01111 10000 0", i, stall_o, flush_o, je_o);
      end
      tick();
    end
    mc_busy_i = 1'b0;
    #1;
    checks++; if (je_o !== 1'b1 || jump_addr_o !== 32'h200) begin errors++; $display("FAIL mc_release: got %b/%h want 1/00000200", je_o, jump_addr_o); end
    checks++; if (stall_cnt_o !== 32'd34) begin errors++; $display("FAIL mc_scnt: got %0d want 34", stall_cnt_o); end
    tick();
    clear_inputs();
    #1;
    checks++; if (flush_cnt_o !== 32'd1) begin errors++; $display("FAIL mc_fcnt: got %0d want 1", flush_cnt_o); end
  endtask

  task automatic test_halt_resume;
    apply_reset();
    halt_req_i = 1'b1;
    #1;
    checks++; if (stall_o !== 5'b00001 || flush_o !== 5'b01110) begin errors++; $display("FAIL halt_req: got %b/%b want 00001/01110", stall_o, flush_o); end
    tick();
    halt_req_i = 1'b0;
    #1;
    checks++; if (state_o !== 2'd1 || stall_o !== 5'b00001 || flush_o !== 5'b00010) begin errors++; $display("FAIL drain: got st %0d %b/%b want 1 00001/00010", state_o, stall_o, flush_o); end
    tick();
    checks++; if (state_o !== 2'd2 || halted_o !== 1'b1 || stall_o !== 5'b11111) begin errors++; $display("FAIL halted: got st %0d h %b stall %b want 2 1 11111", state_o, halted_o, stall_o); end
    halt_req_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    halt_req_i = 1'b0;
    checks++; if (state_o !== 2'd2 || halted_o !== 1'b1 || flush_o !== 5'b0) begin errors++; $display("FAIL halted_hold: got st %0d h %b flush %b want 2 1 00000", state_o, halted_o, flush_o); end
    resume_i = 1'b1; resume_addr_i = 32'h8000_0000;
    #1;
    checks++; if (je_o !== 1'b1 || jump_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL resume_je: got %b/%h want 1/80000000", je_o, jump_addr_o); end
    checks++; if (flush_o !== 5'b11110 || stall_o !== 5'b00000) begin errors++; $display("FAIL resume_vec: got %b/%b want 11110/00000", flush_o, stall_o); end
    tick();
    clear_inputs();
    #1;
    checks++; if (state_o !== 2'd0 || halted_o !== 1'b0) begin errors++; $display("FAIL resume_run: got st %0d h %b want 0 0", state_o, halted_o); end
    checks++; if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd1) begin errors++; $display("FAIL halt_cnt: got %0d/%0d want 1/1", flush_cnt_o, stall_cnt_o); end
  endtask

  task automatic test_reset_in_drain;
    apply_reset();
    halt_req_i = 1'b1;
    tick();
    halt_req_i = 1'b0; mc_busy_i = 1'b1;
    #1;
    checks++; if (state_o !== 2'd1 || stall_o !== 5'b01111 || flush_o !== 5'b10010) begin errors++; $display("FAIL drain_mc: got st %0d %b/%b want 1 01111/10010", state_o, stall_o, flush_o); end
    tick();
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL drain_freeze: got %0d want 1", state_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (flush_o !== 5'b11111 || stall_o !== 5'b00000 || je_o !== 1'b0) begin errors++; $display("FAIL drain_rst_vec: got %b/%b/%b want 11111/00000/0", flush_o, stall_o, je_o); end
    tick();
    checks++; if (state_o !== 2'd0 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin errors++; $display("FAIL drain_rst: got st %0d cnt %0d/%0d want 0 0/0", state_o, stall_cnt_o, flush_cnt_o); end
    rst_i = 1'b0;
    clear_inputs();
  endtask

  task automatic test_saturation;
    apply_reset();
    loaduse_hazard_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        checks++; if (s_stall_cnt !== 4'hE) begin errors++; $display("FAIL sat_14: got %h want e", s_stall_cnt); end
      end
    end
    loaduse_hazard_i = 1'b0;
    checks++; if (s_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_20: got %h want f", s_stall_cnt); end
    checks++; if (stall_cnt_o !== 32'd20) begin errors++; $display("FAIL sat_wide: got %0d want 20", stall_cnt_o); end
    tick();
    checks++; if (s_stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h want f", s_stall_cnt); end
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    test_reset();
    test_loaduse();
    test_jump_loaduse();
    test_mc_busy();
    test_halt_resume();
    test_reset_in_drain();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
